// File: rtl/fnorm_round_seq.sv
// -----------------------------------------------------------------------------
// fnorm_round_seq
//
// Multi-cycle normalize / round / pack stage that sits directly behind the
// add/sub datapath. It accepts an unnormalized result (sign, biased exponent
// already incremented by one, 32-bit magnitude with the implicit one at
// bit 30), left-shifts the magnitude until bit 31 is set, rounds half-up at
// bit 7 and emits a packed IEEE-754 single. One operation is in flight at a
// time. Both sides use a valid/ready handshake.
//
// Parameters:
//   SHIFT_MAX  maximum left-shift distance per NORM cycle (1..31)
//
// Optional feature (compile-time macro):
//   FNORM_SAT_EN  when defined, the final exponent saturates: exp >= 255
//                 packs +/-INF and exp <= 0 packs +/-0. When undefined,
//                 exp[7:0] is packed as-is (wraps).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   block can accept an operand (state == IDLE)
//   in_sign    result sign
//   in_exp     biased exponent plus one, two's complement
//   in_frac    unnormalized magnitude
//   out_valid  out_float valid (state == DONE)
//   out_ready  consumer accepts out_float
//   out_float  packed result {sign, exp[7:0], frac[22:0]}
// -----------------------------------------------------------------------------
module fnorm_round_seq #(
  parameter int SHIFT_MAX = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [31:0] in_exp,
  input  logic [31:0] in_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_e;

  localparam logic [5:0] SHIFT_W = 6'(SHIFT_MAX);

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] frac_q, frac_d;
  logic [31:0] out_float_q, out_float_d;

  logic [5:0]  lz;
  logic [5:0]  shamt;
  logic [24:0] rnd;
  logic [31:0] rounded;

  // Leading-zero count; returns 32 for an all-zero input. Scanning upward
  // lets the highest set bit win.
  function automatic logic [5:0] lzc(input logic [31:0] v);
    lzc = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) lzc = 6'(31 - i);
    end
  endfunction

  // Shift distance for this NORM cycle: never past bit 31, never more than
  // the per-cycle shifter width.
  assign lz    = lzc(frac_q);
  assign shamt = (lz > SHIFT_W) ? SHIFT_W : lz;

  // Half-up rounding at bit 7; the 25th bit catches the mantissa carry.
  assign rnd = {1'b0, frac_q[31:8]} + 25'(frac_q[7]);

`ifdef FNORM_SAT_EN
  logic [31:0] rexp;
  assign rexp = exp_q + 32'(rnd[24]);

  always_comb begin
    if ($signed(rexp) >= 32'sd255) begin
      rounded = {sign_q, 8'hFF, 23'h0};
    end else if ($signed(rexp) <= 32'sd0) begin
      rounded = {sign_q, 31'h0};
    end else begin
      // On a carry the mantissa is 1.000..., so r >> 1 is just r[23:1].
      rounded = {sign_q, rexp[7:0], (rnd[24] ? rnd[23:1] : rnd[22:0])};
    end
  end
`else
  logic [7:0] rexp;
  assign rexp    = exp_q[7:0] + 8'(rnd[24]);
  assign rounded = {sign_q, rexp, (rnd[24] ? rnd[23:1] : rnd[22:0])};
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q      <= 1'b0;
      exp_q       <= '0;
      frac_q      <= '0;
      out_float_q <= '0;
    end else begin
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      out_float_q <= out_float_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    // NOTE: every target gets a hold default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
    out_float_d = out_float_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = in_sign;
          exp_d   = in_exp;
          frac_d  = in_frac;
          state_d = NORM;
        end
      end
      NORM: begin
        if (frac_q == 32'h0) begin
          // Zero magnitude packs +0 regardless of sign.
          out_float_d = 32'h0;
          state_d     = DONE;
        end else if (frac_q[31]) begin
          state_d = ROUND;
        end else begin
          frac_d = frac_q << shamt;
          exp_d  = exp_q - {26'h0, shamt};
        end
      end
      ROUND: begin
        out_float_d = rounded;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_float = out_float_q;
  end

endmodule

// File: tb/tb_fnorm_round_seq.sv
// -----------------------------------------------------------------------------
// tb_fnorm_round_seq
//
// Bench for fnorm_round_seq. Two instances share all inputs: one with
// SHIFT_MAX=1 and one with SHIFT_MAX=4, so value and latency are checked
// for both shifter widths. Expected values come from directed constants and
// from a whole-value arithmetic model (normalize in one step, round, pack).
// Build with +define+FNORM_SAT_EN to exercise the saturating variant.
// -----------------------------------------------------------------------------
module tb_fnorm_round_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sign = 1'b0;
  logic [31:0] in_exp = '0;
  logic [31:0] in_frac = '0;
  logic        out_ready = 1'b1;

  logic [1:0]  in_ready_w;
  logic [1:0]  out_valid_w;
  logic [31:0] out_float_w [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fnorm_round_seq #(.SHIFT_MAX(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_float(out_float_w[0])
  );

  fnorm_round_seq #(.SHIFT_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_float(out_float_w[1])
  );

  function automatic int shift_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // ---------------- reference model ----------------
  function automatic int ref_lz(input logic [31:0] f);
    int n = 0;
    while (n < 32 && f[31-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_float(input bit s, input logic [31:0] e,
                                            input logic [31:0] f);
    int          lz;
    logic [31:0] m;
    logic [31:0] ee;
    logic [31:0] mant;
    if (f == 32'h0) return 32'h0;
    lz   = ref_lz(f);
    m    = f << lz;
    ee   = e - 32'(lz);
    mant = (m >> 8) + {31'h0, m[7]};
    if (mant >= 32'h0100_0000) begin
      mant = mant >> 1;
      ee   = ee + 32'd1;
    end
`ifdef FNORM_SAT_EN
    if ($signed(ee) >= 255) return {s, 8'hFF, 23'h0};
    if ($signed(ee) <= 0)   return {s, 31'h0};
`endif
    return {s, ee[7:0], mant[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] f, input int sm);
    if (f == 32'h0) return 1;
    return (ref_lz(f) + sm - 1) / sm + 2;
  endfunction

  // ---------------- one operation through both instances ----------------
  task automatic run_op(input string name, input bit s, input logic [31:0] e,
                        input logic [31:0] f, input logic [31:0] exp_val,
                        input int lat1, input int lat4);
    bit          seen [2];
    int          lat  [2];
    logic [31:0] val  [2];
    int          wait_n;
    int          exp_lat;
    @(negedge clk);
    wait_n = 0;
    while (in_ready_w != 2'b11 && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (in_ready_w != 2'b11) begin
      checks++;
      errors++;
      $display("FAIL %s idle-wait timeout: in_ready=%b expected 11", name, in_ready_w);
    end
    in_sign  = s;
    in_exp   = e;
    in_frac  = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = '{1'b0, 1'b0};
    lat  = '{0, 0};
    val  = '{32'h0, 32'h0};
    for (int n = 1; n <= 80 && !(seen[0] && seen[1]); n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!seen[d] && out_valid_w[d]) begin
          seen[d] = 1'b1;
          lat[d]  = n;
          val[d]  = out_float_w[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      exp_lat = (d == 0) ? lat1 : lat4;
      checks++;
      if (!seen[d]) begin
        errors++;
        $display("FAIL %s S%0d out_valid timeout: never rose, expected after %0d edges",
                 name, shift_of(d), exp_lat);
      end else begin
        if (val[d] !== exp_val) begin
          errors++;
          $display("FAIL %s S%0d value: got %h expected %h", name, shift_of(d), val[d], exp_val);
        end
        checks++;
        if (lat[d] != exp_lat) begin
          errors++;
          $display("FAIL %s S%0d latency: got %0d expected %0d", name, shift_of(d), lat[d], exp_lat);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_valid_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset S%0d out_valid: got %b expected 0", shift_of(d), out_valid_w[d]);
      end
      checks++;
      if (out_float_w[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset S%0d out_float: got %h expected 00000000", shift_of(d), out_float_w[d]);
      end
      checks++;
      if (in_ready_w[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset S%0d in_ready: got %b expected 1", shift_of(d), in_ready_w[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("normalized", 1'b0, 32'd128, 32'h8000_0000, 32'h4000_0000, 2, 2);
    run_op("leading_zeros", 1'b0, 32'd129, 32'h2000_0000, 32'h3F80_0000, 4, 3);
    run_op("round_carry", 1'b0, 32'd127, 32'hFFFF_FF80, 32'h4000_0000, 2, 2);
    run_op("round_half_up", 1'b0, 32'd128, 32'h8000_0080, 32'h4000_0001, 2, 2);
    run_op("zero", 1'b1, 32'd50, 32'h0, 32'h0, 1, 1);
    run_op("max_lz", 1'b0, 32'd160, 32'h0000_0001, 32'h4080_0000, 33, 10);
`ifdef FNORM_SAT_EN
    run_op("overflow", 1'b1, 32'd300, 32'h8000_0000, 32'hFF80_0000, 2, 2);
    run_op("underflow", 1'b0, 32'd5, 32'h0080_0000, 32'h0000_0000, 10, 4);
`else
    run_op("overflow", 1'b1, 32'd300, 32'h8000_0000, 32'h9600_0000, 2, 2);
    run_op("underflow", 1'b0, 32'd5, 32'h0080_0000, 32'h7E80_0000, 10, 4);
`endif
  endtask

  task automatic test_random();
    bit          s;
    logic [31:0] e;
    logic [31:0] f;
    int          k;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 400));
      k = $urandom_range(0, 33);
      f = (k >= 32) ? 32'h0 : ($urandom >> k);
      run_op("random", s, e, f, ref_float(s, e, f), ref_lat(f, 1), ref_lat(f, 4));
    end
  endtask

  task automatic test_backpressure();
    int wait_n;
    @(negedge clk);
    out_ready = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 32'd128;
    in_frac   = 32'hC000_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_n = 0;
    while (out_valid_w != 2'b11 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    checks++;
    if (out_valid_w != 2'b11) begin
      errors++;
      $display("FAIL backpressure out_valid timeout: got %b expected 11", out_valid_w);
    end
    // Stall five cycles while offering a different operand that must be ignored.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_exp   = 32'd10;
      in_frac  = 32'h0000_0100;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (out_valid_w[d] !== 1'b1 || in_ready_w[d] !== 1'b0) begin
          errors++;
          $display("FAIL stall S%0d handshake: got valid=%b ready=%b expected valid=1 ready=0",
                   shift_of(d), out_valid_w[d], in_ready_w[d]);
        end
        checks++;
        if (out_float_w[d] !== 32'h4040_0000) begin
          errors++;
          $display("FAIL stall S%0d out_float: got %h expected 40400000", shift_of(d), out_float_w[d]);
        end
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b1 || out_valid_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL release S%0d handshake: got ready=%b valid=%b expected ready=1 valid=0",
                 shift_of(d), in_ready_w[d], out_valid_w[d]);
      end
      checks++;
      if (out_float_w[d] !== 32'h4040_0000) begin
        errors++;
        $display("FAIL release S%0d held out_float: got %h expected 40400000", shift_of(d), out_float_w[d]);
      end
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b1) begin
        errors++;
        $display("FAIL not_queued S%0d in_ready: got %b expected 1", shift_of(d), in_ready_w[d]);
      end
    end
  endtask

  task automatic test_reset_in_norm();
    @(negedge clk);
    in_sign  = 1'b1;
    in_exp   = 32'd160;
    in_frac  = 32'h0000_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL busy S%0d in_ready: got %b expected 0", shift_of(d), in_ready_w[d]);
      end
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (out_valid_w[d] !== 1'b0 || in_ready_w[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_norm S%0d handshake: got valid=%b ready=%b expected valid=0 ready=1",
                 shift_of(d), out_valid_w[d], in_ready_w[d]);
      end
      checks++;
      if (out_float_w[d] !== 32'h0) begin
        errors++;
        $display("FAIL rst_norm S%0d out_float: got %h expected 00000000", shift_of(d), out_float_w[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 1'b1, 32'd129, 32'h4000_0000, 32'hC000_0000, 3, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_norm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
